// File: rtl/hls_deadlock_monitor_param.sv
// hls_deadlock_monitor_param: persistence-filtered, optionally sticky deadlock monitor for one HLS dataflow instance
module hls_deadlock_monitor_param #(
  parameter int N_AXIS = 2,
  parameter int N_SUB = 1,
  parameter int HOLD_CYCLES = 1,
  parameter int STICKY = 0,
  parameter int CNT_W = 16,
  parameter int CH_W = $clog2(N_AXIS + 1)
) (
  input  logic                                clock,
  input  logic                                reset,
  input  logic [N_AXIS-1:0]                   axis_block_sigs,
  input  logic [((N_SUB > 0) ? N_SUB : 1)-1:0] inst_idle_sigs,
  input  logic [((N_SUB > 0) ? N_SUB : 1)-1:0] inst_block_sigs,
  input  logic                                clear,
  output logic [2*N_AXIS-1:0]                 axis_block_info,
  output logic                                block,
  output logic [CH_W-1:0]                     first_chan,
  output logic [CNT_W-1:0]                    block_cycles
);
  localparam int PC_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [PC_W-1:0] PC_MAX = PC_W'(HOLD_CYCLES - 1);
  typedef enum logic [1:0] {IDLE, PENDING, BLOCKED} state_t;
  state_t state, state_n;
  logic [PC_W-1:0] pc;
  logic raw, sub_blk, entry, blk_n;
  logic [2*N_AXIS-1:0] code;
  logic [CH_W-1:0] low;
  // sub-instances deadlock only when all are idle-or-blocked and at least one is blocked
  assign sub_blk = (N_SUB > 0) && (&(inst_block_sigs | inst_idle_sigs)) && (|inst_block_sigs);
  assign raw = (|axis_block_sigs) || sub_blk;
  assign block = (state == BLOCKED);
  assign blk_n = (state_n == BLOCKED);
  assign entry = (state != BLOCKED) && blk_n;
  always_comb begin
    code = '0;
    low = CH_W'(N_AXIS);
    for (int i = N_AXIS - 1; i >= 0; i--) begin
      code[2*i +: 2] = axis_block_sigs[i] ? ~(2'b01 << (i % 2)) : 2'b00;
      if (axis_block_sigs[i]) low = CH_W'(i);
    end
  end
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    state_n = raw ? ((HOLD_CYCLES == 1) ? BLOCKED : PENDING) : IDLE;
      PENDING: state_n = !raw ? IDLE : (pc == PC_MAX) ? BLOCKED : PENDING;
      BLOCKED: state_n = (!raw && STICKY == 0) ? IDLE : BLOCKED;
      default: state_n = IDLE;
    endcase
    if (clear) state_n = IDLE;
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
      pc <= '0;
      axis_block_info <= '0;
      first_chan <= '0;
      block_cycles <= '0;
    end else begin
      state <= state_n;
      pc <= (clear || !raw) ? '0 : (pc == PC_MAX) ? pc : pc + 1'b1;
      axis_block_info <= !blk_n ? '0 : (STICKY == 0 || entry) ? code : axis_block_info;
      first_chan <= clear ? '0 : entry ? low : first_chan;
      block_cycles <= !blk_n ? '0 : entry ? CNT_W'(1) : (&block_cycles) ? block_cycles : block_cycles + 1'b1;
    end
  end
endmodule

// File: tb/tb_hls_deadlock_monitor_param.sv
// tb_hls_deadlock_monitor_param: table-driven scoreboard bench over three parameterisations sharing one stimulus bus
module tb_hls_deadlock_monitor_param;
  logic clock = 0, reset = 1, clear = 0;
  logic [1:0] axis = 0, idle = 0, bk = 0;
  logic b0, b1, b2;
  logic [3:0] i0, i1, i2;
  logic [1:0] f0, f1, f2;
  logic [15:0] c0, c1;
  logic [2:0] c2;
  logic [22:0] obs [3];
  typedef struct packed {
    logic rst;
    logic clr;
    logic [1:0] ax;
    logic [1:0] idle;
    logic [1:0] bk;
    logic [22:0] exp;
  } row_t;
  row_t rows[$];
  logic [22:0] sb[$];
  logic [22:0] e;
  int checks = 0, errors = 0;
  always #5 clock = ~clock;
  hls_deadlock_monitor_param #(.N_AXIS(2), .N_SUB(2), .HOLD_CYCLES(1), .STICKY(0), .CNT_W(16)) d0 (
    .clock(clock), .reset(reset), .axis_block_sigs(axis), .inst_idle_sigs(idle), .inst_block_sigs(bk),
    .clear(clear), .axis_block_info(i0), .block(b0), .first_chan(f0), .block_cycles(c0));
  hls_deadlock_monitor_param #(.N_AXIS(2), .N_SUB(0), .HOLD_CYCLES(4), .STICKY(0), .CNT_W(16)) d1 (
    .clock(clock), .reset(reset), .axis_block_sigs(axis), .inst_idle_sigs(idle[0]), .inst_block_sigs(bk[0]),
    .clear(clear), .axis_block_info(i1), .block(b1), .first_chan(f1), .block_cycles(c1));
  hls_deadlock_monitor_param #(.N_AXIS(2), .N_SUB(0), .HOLD_CYCLES(2), .STICKY(1), .CNT_W(3)) d2 (
    .clock(clock), .reset(reset), .axis_block_sigs(axis), .inst_idle_sigs(idle[0]), .inst_block_sigs(bk[0]),
    .clear(clear), .axis_block_info(i2), .block(b2), .first_chan(f2), .block_cycles(c2));
  assign obs[0] = {b0, i0, f0, c0};
  assign obs[1] = {b1, i1, f1, c1};
  assign obs[2] = {b2, i2, f2, 13'd0, c2};

  function automatic row_t mk(logic r, logic c, logic [1:0] a, logic [1:0] id, logic [1:0] k,
                              logic b, logic [3:0] inf, logic [1:0] fc, int cyc);
    return {r, c, a, id, k, b, inf, fc, 16'(cyc)};
  endfunction

  task automatic drive(input row_t r);
    @(negedge clock);
    reset = r.rst;
    clear = r.clr;
    axis = r.ax;
    idle = r.idle;
    bk = r.bk;
    sb.push_back(r.exp);
  endtask

  task automatic test_reset;
    rows.push_back(mk(1, 0, 2'b11, 2'b01, 2'b10, 0, 4'b0, 0, 0));
    rows.push_back(mk(1, 1, 2'b11, 2'b00, 2'b00, 0, 4'b0, 0, 0));
    foreach (rows[k]) begin
      drive(rows[k]);
      @(posedge clock); #1;
      e = sb.pop_front();
      for (int d = 0; d < 3; d++) begin
        checks++;
        if (obs[d] !== e) begin
          errors++;
          $display("FAIL reset[%0d] dut%0d: got b=%b info=%b fc=%0d cyc=%0d, want b=%b info=%b fc=%0d cyc=%0d",
                   k, d, obs[d][22], obs[d][21:18], obs[d][17:16], obs[d][15:0], e[22], e[21:18], e[17:16], e[15:0]);
        end
      end
    end
    rows.delete();
  endtask

  task automatic test_basic;
    rows.push_back(mk(1, 0, 2'b00, 2'b00, 2'b00, 0, 4'b0000, 0, 0));
    rows.push_back(mk(0, 0, 2'b01, 2'b00, 2'b00, 1, 4'b0010, 0, 1));
    rows.push_back(mk(0, 0, 2'b00, 2'b00, 2'b00, 0, 4'b0000, 0, 0));
    rows.push_back(mk(0, 0, 2'b11, 2'b00, 2'b00, 1, 4'b0110, 0, 1));
    rows.push_back(mk(0, 0, 2'b10, 2'b00, 2'b00, 1, 4'b0100, 0, 2));
    rows.push_back(mk(0, 0, 2'b10, 2'b00, 2'b00, 1, 4'b0100, 0, 3));
    rows.push_back(mk(0, 0, 2'b00, 2'b00, 2'b00, 0, 4'b0000, 0, 0));
    rows.push_back(mk(0, 0, 2'b10, 2'b00, 2'b00, 1, 4'b0100, 1, 1));
    rows.push_back(mk(0, 0, 2'b00, 2'b00, 2'b00, 0, 4'b0000, 1, 0));
    rows.push_back(mk(0, 0, 2'b00, 2'b01, 2'b10, 1, 4'b0000, 2, 1));
    rows.push_back(mk(0, 0, 2'b00, 2'b00, 2'b10, 0, 4'b0000, 2, 0));
    rows.push_back(mk(0, 0, 2'b00, 2'b11, 2'b00, 0, 4'b0000, 2, 0));
    rows.push_back(mk(0, 0, 2'b10, 2'b11, 2'b01, 1, 4'b0100, 1, 1));
    rows.push_back(mk(0, 0, 2'b00, 2'b11, 2'b01, 1, 4'b0000, 1, 2));
    rows.push_back(mk(0, 0, 2'b00, 2'b00, 2'b00, 0, 4'b0000, 1, 0));
    foreach (rows[k]) begin
      drive(rows[k]);
      @(posedge clock); #1;
      e = sb.pop_front();
      checks++;
      if (obs[0] !== e) begin
        errors++;
        $display("FAIL basic[%0d]: got b=%b info=%b fc=%0d cyc=%0d, want b=%b info=%b fc=%0d cyc=%0d",
                 k, obs[0][22], obs[0][21:18], obs[0][17:16], obs[0][15:0], e[22], e[21:18], e[17:16], e[15:0]);
      end
    end
    rows.delete();
  endtask

  task automatic test_hold;
    rows.push_back(mk(1, 0, 2'b00, 2'b00, 2'b00, 0, 4'b0000, 0, 0));
    repeat (3) rows.push_back(mk(0, 0, 2'b01, 2'b00, 2'b00, 0, 4'b0000, 0, 0));
    rows.push_back(mk(0, 0, 2'b00, 2'b00, 2'b00, 0, 4'b0000, 0, 0));
    repeat (3) rows.push_back(mk(0, 0, 2'b01, 2'b00, 2'b00, 0, 4'b0000, 0, 0));
    rows.push_back(mk(0, 0, 2'b01, 2'b00, 2'b00, 1, 4'b0010, 0, 1));
    rows.push_back(mk(0, 0, 2'b01, 2'b00, 2'b00, 1, 4'b0010, 0, 2));
    rows.push_back(mk(0, 0, 2'b11, 2'b00, 2'b00, 1, 4'b0110, 0, 3));
    rows.push_back(mk(0, 0, 2'b00, 2'b00, 2'b00, 0, 4'b0000, 0, 0));
    repeat (3) rows.push_back(mk(0, 0, 2'b10, 2'b00, 2'b00, 0, 4'b0000, 0, 0));
    rows.push_back(mk(0, 0, 2'b10, 2'b00, 2'b00, 1, 4'b0100, 1, 1));
    rows.push_back(mk(0, 0, 2'b00, 2'b00, 2'b00, 0, 4'b0000, 1, 0));
    foreach (rows[k]) begin
      drive(rows[k]);
      @(posedge clock); #1;
      e = sb.pop_front();
      checks++;
      if (obs[1] !== e) begin
        errors++;
        $display("FAIL hold[%0d]: got b=%b info=%b fc=%0d cyc=%0d, want b=%b info=%b fc=%0d cyc=%0d",
                 k, obs[1][22], obs[1][21:18], obs[1][17:16], obs[1][15:0], e[22], e[21:18], e[17:16], e[15:0]);
      end
    end
    rows.delete();
  endtask

  task automatic test_sticky;
    rows.push_back(mk(1, 0, 2'b00, 2'b00, 2'b00, 0, 4'b0000, 0, 0));
    rows.push_back(mk(0, 0, 2'b10, 2'b00, 2'b00, 0, 4'b0000, 0, 0));
    for (int n = 1; n <= 4; n++) rows.push_back(mk(0, 0, 2'b10, 2'b00, 2'b00, 1, 4'b0100, 1, n));
    for (int n = 5; n <= 7; n++) rows.push_back(mk(0, 0, 2'b00, 2'b00, 2'b00, 1, 4'b0100, 1, n));
    rows.push_back(mk(0, 0, 2'b01, 2'b00, 2'b00, 1, 4'b0100, 1, 7));
    rows.push_back(mk(0, 1, 2'b00, 2'b00, 2'b00, 0, 4'b0000, 0, 0));
    rows.push_back(mk(0, 0, 2'b00, 2'b00, 2'b00, 0, 4'b0000, 0, 0));
    foreach (rows[k]) begin
      drive(rows[k]);
      @(posedge clock); #1;
      e = sb.pop_front();
      checks++;
      if (obs[2] !== e) begin
        errors++;
        $display("FAIL sticky[%0d]: got b=%b info=%b fc=%0d cyc=%0d, want b=%b info=%b fc=%0d cyc=%0d",
                 k, obs[2][22], obs[2][21:18], obs[2][17:16], obs[2][15:0], e[22], e[21:18], e[17:16], e[15:0]);
      end
    end
    rows.delete();
  endtask

  task automatic test_saturate_reset_clear;
    rows.push_back(mk(0, 0, 2'b01, 2'b00, 2'b00, 0, 4'b0000, 0, 0));
    for (int n = 1; n <= 9; n++) rows.push_back(mk(0, 0, 2'b01, 2'b00, 2'b00, 1, 4'b0010, 0, (n > 7) ? 7 : n));
    rows.push_back(mk(1, 0, 2'b01, 2'b00, 2'b00, 0, 4'b0000, 0, 0));
    rows.push_back(mk(0, 0, 2'b01, 2'b00, 2'b00, 0, 4'b0000, 0, 0));
    rows.push_back(mk(0, 0, 2'b01, 2'b00, 2'b00, 1, 4'b0010, 0, 1));
    rows.push_back(mk(0, 1, 2'b01, 2'b00, 2'b00, 0, 4'b0000, 0, 0));
    rows.push_back(mk(0, 0, 2'b01, 2'b00, 2'b00, 0, 4'b0000, 0, 0));
    rows.push_back(mk(0, 0, 2'b11, 2'b00, 2'b00, 1, 4'b0110, 0, 1));
    rows.push_back(mk(0, 0, 2'b00, 2'b00, 2'b00, 1, 4'b0110, 0, 2));
    foreach (rows[k]) begin
      drive(rows[k]);
      @(posedge clock); #1;
      e = sb.pop_front();
      checks++;
      if (obs[2] !== e) begin
        errors++;
        $display("FAIL sat_rst_clr[%0d]: got b=%b info=%b fc=%0d cyc=%0d, want b=%b info=%b fc=%0d cyc=%0d",
                 k, obs[2][22], obs[2][21:18], obs[2][17:16], obs[2][15:0], e[22], e[21:18], e[17:16], e[15:0]);
      end
    end
    rows.delete();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_hold();
    test_sticky();
    test_saturate_reset_clear();
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d leftover entries, want 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
